// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory combinationally and buffers {pc, instr} for decode.
// Optional FETCH_MISALIGN_EN adds a sticky misalignFault on misaligned redirects.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 48,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FIFO_DEPTH  = 2
) (
  input  logic                   clock,
  input  logic                   resetN,
  output logic [ADDR_WIDTH-1:0]  pcAddressOutput,
  input  logic [INSTR_WIDTH-1:0] instructionInput,
  input  logic                   redirectValid,
  input  logic [ADDR_WIDTH-1:0]  redirectTarget,
  output logic                   fetchValid,
  input  logic                   fetchReady,
  output logic [INSTR_WIDTH-1:0] fetchInstruction,
  output logic [ADDR_WIDTH-1:0]  fetchPc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                   misalignFault
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  fetch_entry_t [FIFO_DEPTH-1:0] fifo_q, fifo_d;
  fetch_entry_t                  head_q, head_d, head_out;
  logic [ADDR_WIDTH-1:0]         pc_q, pc_d, redir_pc;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          push, pop, full, fault_active;

`ifdef FETCH_MISALIGN_EN
  logic fault_q, fault_d;

  assign redir_pc     = redirectTarget;
  assign fault_active = fault_q;
  assign fault_d      = fault_q | (redirectValid & (|redirectTarget[1:0]));
  assign misalignFault = fault_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end
`else
  logic unused_tgt_lsbs;

  // Low target bits are dropped, so the PC can never become misaligned.
  assign redir_pc        = {redirectTarget[ADDR_WIDTH-1:2], 2'b00};
  assign fault_active    = 1'b0;
  assign unused_tgt_lsbs = ^redirectTarget[1:0];
`endif

  assign pcAddressOutput = pc_q;
  assign fetchValid      = (count_q != '0);
  assign full            = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop             = fetchValid & fetchReady;
  assign push            = !redirectValid & !fault_active & (!full | pop);

  // Head outputs hold their last presented value while the buffer is empty.
  assign head_out         = fetchValid ? fifo_q[rd_ptr_q] : head_q;
  assign head_d           = head_out;
  assign fetchPc          = head_out.pc;
  assign fetchInstruction = head_out.instr;

  always_comb begin
    fifo_d   = fifo_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirectValid) begin
      // Flush wins over everything; a same-cycle pop is already owned by decode.
      pc_d     = redir_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q].pc    = pc_q;
        fifo_d[wr_ptr_q].instr = instructionInput;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        pc_d                   = pc_q + ADDR_WIDTH'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fifo_q   <= '0;
      head_q   <= '0;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      head_q   <= head_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector table plus a mid-cycle async reset sequence.
module tb_instruction_fetch_unit;
  localparam int AW = 48;
  localparam int IW = 32;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic [AW-1:0] pcAddressOutput;
  logic [IW-1:0] instructionInput;
  logic          redirectValid = 1'b0;
  logic [AW-1:0] redirectTarget = '0;
  logic          fetchValid;
  logic          fetchReady = 1'b0;
  logic [IW-1:0] fetchInstruction;
  logic [AW-1:0] fetchPc;
`ifdef FETCH_MISALIGN_EN
  logic          misalignFault;
`endif

  instruction_fetch_unit dut (
    .clock            (clock),
    .resetN           (resetN),
    .pcAddressOutput  (pcAddressOutput),
    .instructionInput (instructionInput),
    .redirectValid    (redirectValid),
    .redirectTarget   (redirectTarget),
    .fetchValid       (fetchValid),
    .fetchReady       (fetchReady),
    .fetchInstruction (fetchInstruction),
    .fetchPc          (fetchPc)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalignFault    (misalignFault)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory model: data is a fixed function of the address.
  assign instructionInput = pcAddressOutput[31:0] ^ 32'hA5A5_0000;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [47:0] tgt;
    bit          vld;
    logic [47:0] fpc;
    logic [47:0] addr;
    bit          flt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(bit rst, bit rdy, bit rv, logic [47:0] tgt,
                              bit vld, logic [47:0] fpc, logic [47:0] addr, bit flt = 1'b0);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
    v.vld = vld; v.fpc = fpc; v.addr = addr; v.flt = flt;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // rst rdy rv tgt  | vld fetchPc pcAddr
    add(1, 1, 0, 48'h0,   0, 48'h0,   48'h0);
    add(0, 1, 0, 48'h0,   1, 48'h0,   48'h4);
    add(0, 1, 0, 48'h0,   1, 48'h4,   48'h8);
    add(0, 1, 0, 48'h0,   1, 48'h8,   48'hC);
    add(0, 1, 0, 48'h0,   1, 48'hC,   48'h10);
    // back-pressure: buffer fills at 2, pc holds at 8
    add(1, 0, 0, 48'h0,   0, 48'h0,   48'h0);
    add(0, 0, 0, 48'h0,   1, 48'h0,   48'h4);
    add(0, 0, 0, 48'h0,   1, 48'h0,   48'h8);
    add(0, 0, 0, 48'h0,   1, 48'h0,   48'h8);
    add(0, 0, 0, 48'h0,   1, 48'h0,   48'h8);
    add(0, 1, 0, 48'h0,   1, 48'h0,   48'h8);
    add(0, 1, 0, 48'h0,   1, 48'h4,   48'hC);
    add(0, 1, 0, 48'h0,   1, 48'h8,   48'h10);
    // redirect with a full buffer and a same-cycle pop
    add(1, 0, 0, 48'h0,   0, 48'h0,   48'h0);
    add(0, 0, 0, 48'h0,   1, 48'h0,   48'h4);
    add(0, 1, 1, 48'h100, 1, 48'h0,   48'h8);
    add(0, 1, 0, 48'h0,   0, 48'h0,   48'h100);
    add(0, 1, 0, 48'h0,   1, 48'h100, 48'h104);
    // wrap at the top of the address space
    add(0, 1, 1, 48'hFFFF_FFFF_FFFC, 1, 48'h104, 48'h108);
    add(0, 1, 0, 48'h0,   0, 48'h104, 48'hFFFF_FFFF_FFFC);
    add(0, 1, 0, 48'h0,   1, 48'hFFFF_FFFF_FFFC, 48'h0);
    add(0, 1, 0, 48'h0,   1, 48'h0,   48'h4);
    // back-to-back redirects, last one wins
    add(0, 1, 1, 48'h200, 1, 48'h4,   48'h8);
    add(0, 1, 1, 48'h300, 0, 48'h4,   48'h200);
    add(0, 1, 0, 48'h0,   0, 48'h4,   48'h300);
    add(0, 1, 0, 48'h0,   1, 48'h300, 48'h304);
    // misaligned redirect target
    add(0, 1, 1, 48'h102, 1, 48'h304, 48'h308, 1'b0);
`ifdef FETCH_MISALIGN_EN
    add(0, 1, 0, 48'h0,   0, 48'h304, 48'h102, 1'b1);
    add(0, 1, 0, 48'h0,   0, 48'h304, 48'h102, 1'b1);
    add(0, 1, 0, 48'h0,   0, 48'h304, 48'h102, 1'b1);
`else
    add(0, 1, 0, 48'h0,   0, 48'h304, 48'h100);
    add(0, 1, 0, 48'h0,   1, 48'h100, 48'h104);
`endif

    #12;
    chk("reset vld",   {63'd0, fetchValid}, 64'd0);
    chk("reset pc",    {16'd0, fetchPc}, 64'd0);
    chk("reset instr", {32'd0, fetchInstruction}, 64'd0);
    chk("reset addr",  {16'd0, pcAddressOutput}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      if (vecs[i].rst) begin
        resetN = 1'b0;
        #1;
        resetN = 1'b1;
      end
      fetchReady     = vecs[i].rdy;
      redirectValid  = vecs[i].rv;
      redirectTarget = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d vld", i),  {63'd0, fetchValid}, {63'd0, vecs[i].vld});
      chk($sformatf("v%0d fpc", i),  {16'd0, fetchPc}, {16'd0, vecs[i].fpc});
      chk($sformatf("v%0d addr", i), {16'd0, pcAddressOutput}, {16'd0, vecs[i].addr});
      if (vecs[i].vld)
        chk($sformatf("v%0d instr", i), {32'd0, fetchInstruction},
            {32'd0, vecs[i].fpc[31:0] ^ 32'hA5A5_0000});
`ifdef FETCH_MISALIGN_EN
      chk($sformatf("v%0d fault", i), {63'd0, misalignFault}, {63'd0, vecs[i].flt});
`endif
    end

    // Async reset asserted between edges while streaming
    @(negedge clock);
    fetchReady    = 1'b1;
    redirectValid = 1'b0;
    @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    chk("async vld",   {63'd0, fetchValid}, 64'd0);
    chk("async pc",    {16'd0, fetchPc}, 64'd0);
    chk("async instr", {32'd0, fetchInstruction}, 64'd0);
    chk("async addr",  {16'd0, pcAddressOutput}, 64'd0);
`ifdef FETCH_MISALIGN_EN
    chk("async fault", {63'd0, misalignFault}, 64'd0);
`endif
    @(posedge clock);
    #1;
    chk("held vld",  {63'd0, fetchValid}, 64'd0);
    chk("held addr", {16'd0, pcAddressOutput}, 64'd0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    chk("rel vld",  {63'd0, fetchValid}, 64'd0);
    chk("rel addr", {16'd0, pcAddressOutput}, 64'd0);
    @(negedge clock);
    #1;
    chk("restart vld",   {63'd0, fetchValid}, 64'd1);
    chk("restart pc",    {16'd0, fetchPc}, 64'd0);
    chk("restart instr", {32'd0, fetchInstruction}, {32'd0, 32'hA5A5_0000});
    chk("restart addr",  {16'd0, pcAddressOutput}, 64'd4);
    @(negedge clock);
    #1;
    chk("restart2 pc",   {16'd0, fetchPc}, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
